// File: rtl/sigmoid_pkg.sv
// Shared constants and helpers for the sigmoid activation engine.
// grid_addr must produce exactly the addresses present in the sigmoid ROM.
package sigmoid_pkg;

   localparam int         DATA_W   = 16;
   localparam int         IDX_MAX  = 60;
   localparam int         IDX_W    = 6;
   localparam logic [7:0] HALF_Q08 = 8'h80;

   typedef struct packed {
      logic             sat;
      logic [IDX_W-1:0] idx;
   } sig_idx_t;

   // Q8.8 address of grid point k*0.1, truncated the same way the ROM table was built.
   function automatic logic [DATA_W-1:0] grid_addr(input logic [IDX_W-1:0] k);
      logic [19:0] num;
      num = {6'd0, k, 8'd0} + 20'd5;
      return DATA_W'(num / 20'd10);
   endfunction

   // Round-to-nearest of |x|/0.1, clamped to the last grid index.
   function automatic sig_idx_t sig_index(input logic [DATA_W:0] mag);
      logic [20:0] t;
      logic [12:0] raw;
      sig_idx_t    r;
      t     = {4'd0, mag} * 21'd10 + 21'd128;
      raw   = t[20:8];
      r.sat = (raw > 13'(IDX_MAX));
      r.idx = r.sat ? IDX_W'(IDX_MAX) : raw[IDX_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/sigmoid_quant.sv
// Combinational |x| / round / clamp / grid-address logic for one Q8.8 sample.
// No state; feeds the stage-A registers in the top.
module sigmoid_quant
   import sigmoid_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic              sign_o,
   output logic              sat_o,
   output logic [DATA_W-1:0] addr_o
);

   logic [DATA_W:0] mag;
   sig_idx_t        si;

   always_comb begin
      sign_o = data_i[DATA_W-1];
      // 17-bit magnitude so that -32768 maps to +32768.
      mag    = sign_o ? ({1'b0, ~data_i} + 17'd1) : {1'b0, data_i};
      si     = sig_index(mag);
      sat_o  = si.sat;
      addr_o = grid_addr(si.idx);
   end

endmodule

// File: rtl/sigmoid_act.sv
// Streaming sigmoid: Q8.8 in, Q0.8 out, 2-cycle latency, 1 sample/cycle.
// Stage A drives the ROM address; in_ready drops only when both stages are full and out_ready is low.
module sigmoid_act
   import sigmoid_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sat
);

   localparam logic [8:0] ONE_Q08 = {HALF_Q08, 1'b0};

   logic              a_valid_q;
   logic [DATA_W-1:0] rom_addr_q;
   logic              sign_q;
   logic              sat_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_sat_q;

   logic              quant_sign;
   logic              quant_sat;
   logic [DATA_W-1:0] quant_addr;
   logic              b_adv;
   logic              a_adv;
   logic              in_xfer;
   logic [8:0]        res_d;
   logic              unused_rom_hi;

   sigmoid_quant u_quant (
      .data_i (in_data),
      .sign_o (quant_sign),
      .sat_o  (quant_sat),
      .addr_o (quant_addr)
   );

   always_comb begin
      b_adv    = !out_valid_q || out_ready;
      a_adv    = a_valid_q && b_adv;
      in_ready = !a_valid_q || b_adv;
      in_xfer  = in_valid && in_ready;
      // Negative inputs use sigmoid(-x) = 1 - sigmoid(x); ROM data is never below 0x80.
      res_d    = sign_q ? (ONE_Q08 - {1'b0, rom_data[7:0]}) : {1'b0, rom_data[7:0]};
   end

   assign unused_rom_hi = ^rom_data[DATA_W-1:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q  <= 1'b0;
         rom_addr_q <= '0;
         sign_q     <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         if (in_ready) a_valid_q <= in_valid;
         if (in_xfer) begin
            rom_addr_q <= quant_addr;
            sign_q     <= quant_sign;
            sat_q      <= quant_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         if (b_adv) out_valid_q <= a_valid_q;
         if (a_adv) begin
            out_data_q <= {7'd0, res_d};
            out_sat_q  <= sat_q;
         end
      end
   end

   assign rom_addr  = rom_addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sigmoid_act.sv
// Directed bench for sigmoid_act with a behavioural sigmoid ROM on rom_addr.
module tb_sigmoid_act;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sat;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sigmoid_act dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   // ROM: only exact grid addresses hold data; anything else reads 0.
   logic [7:0] rom_tab [0:60];
   initial begin
      for (int k = 0; k <= 60; k++) begin
         int r;
         r = int'(256.0 / (1.0 + $exp(-0.1 * k)));
         if (r > 255) r = 255;
         rom_tab[k] = 8'(r);
      end
   end

   always_comb begin
      rom_data = 16'h0000;
      for (int k = 0; k <= 60; k++)
         if (rom_addr == 16'((256 * k + 5) / 10)) rom_data = {8'h00, rom_tab[k]};
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] x;
      logic [15:0] addr;
      logic [15:0] data;
      logic        sat;
   } vec_t;

   vec_t vec [0:8];

   logic [15:0] s_in [$];
   logic [15:0] s_exp [$];
   logic [15:0] s_got [$];
   int          s_cyc [$];

   task automatic run_stream(input int stall, output int ready_lows);
      int     i = 0;
      int     acc = 0;
      bit     fell = 0;
      logic   prev_stall = 1'b0;
      logic [15:0] prev_addr = 16'h0;
      ready_lows = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= stall);
         in_valid  = (i < s_in.size());
         in_data   = in_valid ? s_in[i] : 16'h0000;
         #1;
         if (prev_stall) check("stall_rom_addr_hold", rom_addr, prev_addr);
         if (out_valid && out_ready) begin
            s_got.push_back(out_data);
            s_cyc.push_back(cyc);
         end
         if (in_valid && !in_ready) begin
            ready_lows++;
            if (!fell && stall > 0) check("accepts_before_stall", 16'(acc), 16'd2);
            fell = 1;
         end
         if (in_valid && in_ready) begin
            acc++;
            i++;
         end
         prev_stall = !in_ready;
         prev_addr  = rom_addr;
         if (i == s_in.size() && s_got.size() == s_in.size()) break;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("stream_count", 16'(s_got.size()), 16'(s_in.size()));
      for (int j = 0; j < s_got.size() && j < s_exp.size(); j++)
         check($sformatf("stream_data[%0d]", j), s_got[j], s_exp[j]);
   endtask

   initial begin
      int lows;
      vec[0] = '{16'h0000, 16'h0000, 16'h0080, 1'b0};
      vec[1] = '{16'h0100, 16'h0100, 16'h00BB, 1'b0};
      vec[2] = '{16'hFF00, 16'h0100, 16'h0045, 1'b0};
      vec[3] = '{16'h0033, 16'h0033, 16'h008D, 1'b0};
      vec[4] = '{16'h002C, 16'h0033, 16'h008D, 1'b0};
      vec[5] = '{16'hFFD4, 16'h0033, 16'h0073, 1'b0};
      vec[6] = '{16'h0600, 16'h0600, 16'h00FF, 1'b0};
      vec[7] = '{16'h7FFF, 16'h0600, 16'h00FF, 1'b1};
      vec[8] = '{16'h8000, 16'h0600, 16'h0001, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
      #3;
      check("rst_out_valid", 16'(out_valid), 16'h0);
      check("rst_rom_addr", rom_addr, 16'h0);
      check("rst_out_data", out_data, 16'h0);
      check("rst_out_sat", 16'(out_sat), 16'h0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      check("post_rst_in_ready", 16'(in_ready), 16'h1);

      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = vec[v].x; out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         check($sformatf("v%0d_rom_addr", v), rom_addr, vec[v].addr);
         check($sformatf("v%0d_valid_early", v), 16'(out_valid), 16'h0);
         @(negedge clk); #1;
         check($sformatf("v%0d_valid", v), 16'(out_valid), 16'h1);
         check($sformatf("v%0d_data", v), out_data, vec[v].data);
         check($sformatf("v%0d_sat", v), 16'(out_sat), 16'(vec[v].sat));
         @(negedge clk); #1;
         check($sformatf("v%0d_drained", v), 16'(out_valid), 16'h0);
      end

      // Backpressure: four samples, out_ready low for the first 5 cycles.
      s_in = '{16'h0000, 16'h0100, 16'hFF00, 16'h0033};
      s_exp = '{16'h0080, 16'h00BB, 16'h0045, 16'h008D};
      s_got.delete(); s_cyc.delete();
      run_stream(5, lows);
      check("bp_saw_in_ready_low", 16'(lows > 0), 16'h1);

      // Reset with both stages full.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0100;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("full_in_ready", 16'(in_ready), 16'h0);
      check("full_out_valid", 16'(out_valid), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 16'(out_valid), 16'h0);
      check("midrst_out_data", out_data, 16'h0);
      check("midrst_rom_addr", rom_addr, 16'h0);
      check("midrst_in_ready", 16'(in_ready), 16'h1);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk); #1;
      check("after_rst_in_ready", 16'(in_ready), 16'h1);
      check("after_rst_no_stale", 16'(out_valid), 16'h0);

      // Full throughput.
      s_in.delete(); s_exp.delete(); s_got.delete(); s_cyc.delete();
      for (int v = 3; v < 9; v++) begin
         s_in.push_back(vec[v].x);
         s_exp.push_back(vec[v].data);
      end
      run_stream(0, lows);
      check("tp_in_ready_never_low", 16'(lows), 16'h0);
      if (s_cyc.size() == 6) check("tp_one_per_cycle", 16'(s_cyc[5] - s_cyc[0]), 16'd5);
      else check("tp_result_count", 16'(s_cyc.size()), 16'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
